// File: rtl/conv_8x32_pkg.sv
// Shared types and constants for the 8x32 convolution coprocessor.
package conv_8x32_pkg;

    localparam int unsigned CONV_DATA_WIDTH = 8;
    localparam int unsigned M_MAX           = 8;
    localparam int unsigned N_MAX           = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/conv_8x32_comp_less_or_eq.sv
// Unsigned a <= b comparator used for the sequencer loop bounds.
module conv_8x32_comp_less_or_eq #(
    parameter int unsigned WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             le
);

    assign le = (a <= b);

endmodule

// File: rtl/conv_8x32_window_seq.sv
// Walks y[n] = sum_k h[k]*x[n-k] over the full linear convolution, one
// (x_addr, h_addr, y_addr) beat per valid tap, with a setup bubble per output.
module conv_8x32_window_seq
    import conv_8x32_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CONV_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic [DATA_WIDTH-1:0] m_len_in,
    input  logic [DATA_WIDTH-1:0] n_len_in,
    input  logic                  ready_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] x_addr_out,
    output logic [DATA_WIDTH-1:0] h_addr_out,
    output logic [DATA_WIDTH:0]   y_addr_out,
    output logic                  first_out,
    output logic                  last_out,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam int unsigned IW = DATA_WIDTH + 1;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] m_len, n_len;
    logic [IW-1:0]         n_idx, k_idx, k_lo, k_hi;
    logic [IW-1:0]         n_m1, m_m1, n_end;
    logic                  n_past_x, n_in_h, k_at_hi;
    logic                  beat_ok;

    assign n_m1  = IW'(n_len) - IW'(1);
    assign m_m1  = IW'(m_len) - IW'(1);
    assign n_end = IW'(n_len) + IW'(m_len) - IW'(2);

    conv_8x32_comp_less_or_eq #(.WIDTH(IW)) u_cmp_lo (
        .a  (n_m1),
        .b  (n_idx),
        .le (n_past_x)
    );

    conv_8x32_comp_less_or_eq #(.WIDTH(IW)) u_cmp_hi (
        .a  (n_idx),
        .b  (m_m1),
        .le (n_in_h)
    );

    conv_8x32_comp_less_or_eq #(.WIDTH(IW)) u_cmp_last (
        .a  (k_hi),
        .b  (k_idx),
        .le (k_at_hi)
    );

    assign beat_ok = (state == RUN) && ready_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_in) begin
                    state_nxt = (m_len_in == '0 || n_len_in == '0) ? DONE : SETUP;
                end
            end
            SETUP: state_nxt = RUN;
            RUN: begin
                if (ready_in && k_at_hi) begin
                    state_nxt = (n_idx == n_end) ? DONE : SETUP;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Tap window for the current n is resolved once in SETUP and held in k_lo/k_hi.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_len <= '0;
            n_len <= '0;
            n_idx <= '0;
            k_idx <= '0;
            k_lo  <= '0;
            k_hi  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        m_len <= m_len_in;
                        n_len <= n_len_in;
                        n_idx <= '0;
                    end
                end
                SETUP: begin
                    k_lo  <= n_past_x ? (n_idx - n_m1) : '0;
                    k_idx <= n_past_x ? (n_idx - n_m1) : '0;
                    k_hi  <= n_in_h ? n_idx : m_m1;
                end
                RUN: begin
                    if (beat_ok) begin
                        if (!k_at_hi) begin
                            k_idx <= k_idx + IW'(1);
                        end else if (n_idx != n_end) begin
                            n_idx <= n_idx + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        valid_out  = 1'b0;
        x_addr_out = '0;
        h_addr_out = '0;
        y_addr_out = '0;
        first_out  = 1'b0;
        last_out   = 1'b0;
        if (state == RUN) begin
            valid_out  = 1'b1;
            x_addr_out = DATA_WIDTH'(n_idx - k_idx);
            h_addr_out = DATA_WIDTH'(k_idx);
            y_addr_out = n_idx;
            first_out  = (k_idx == k_lo);
            last_out   = k_at_hi;
        end
        busy_out = (state == SETUP) || (state == RUN);
        done_out = (state == DONE);
    end

endmodule

// File: tb/tb_conv_8x32_window_seq.sv
// Directed self-checking bench for conv_8x32_window_seq.
module tb_conv_8x32_window_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_in = 1'b0;
    logic [7:0] m_len_in = '0;
    logic [7:0] n_len_in = '0;
    logic       ready_in = 1'b0;
    logic       valid_out;
    logic [7:0] x_addr_out;
    logic [7:0] h_addr_out;
    logic [8:0] y_addr_out;
    logic       first_out;
    logic       last_out;
    logic       busy_out;
    logic       done_out;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_x [256];
    logic [7:0] exp_h [256];
    logic [8:0] exp_y [256];
    logic       exp_f [256];
    logic       exp_l [256];

    conv_8x32_window_seq #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_in   (start_in),
        .m_len_in   (m_len_in),
        .n_len_in   (n_len_in),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .x_addr_out (x_addr_out),
        .h_addr_out (h_addr_out),
        .y_addr_out (y_addr_out),
        .first_out  (first_out),
        .last_out   (last_out),
        .busy_out   (busy_out),
        .done_out   (done_out)
    );

    always #5 clk = ~clk;

    function automatic int build_model(input int m, input int n);
        int c;
        int lo;
        int hi;
        c = 0;
        for (int yy = 0; yy <= m + n - 2; yy++) begin
            lo = (yy - n + 1 > 0) ? yy - n + 1 : 0;
            hi = (yy < m - 1) ? yy : m - 1;
            for (int kk = lo; kk <= hi; kk++) begin
                exp_x[c] = 8'(yy - kk);
                exp_h[c] = 8'(kk);
                exp_y[c] = 9'(yy);
                exp_f[c] = (kk == lo);
                exp_l[c] = (kk == hi);
                c++;
            end
        end
        return c;
    endfunction

    // Runs one job from a start pulse; beats are checked against exp_* as they
    // are accepted. abort_at >= 0 raises rst asynchronously at that beat.
    task automatic run_job(input int m, input int n, input int nexp, input bit rnd,
                           input int abort_at, input int poke_at,
                           output int beats, output int lasts, output int done_cyc,
                           output bit busy_seen);
        int  cyc;
        int  b;
        bit  fin;
        bit  hold;
        logic [29:0] saved;
        b = 0; lasts = 0; done_cyc = -1; busy_seen = 0; hold = 0; saved = '0;
        @(negedge clk);
        start_in = 1'b1; m_len_in = 8'(m); n_len_in = 8'(n); ready_in = 1'b0;
        @(negedge clk);
        start_in = 1'b0;
        cyc = 1;
        fin = 0;
        while (!fin) begin
            if (busy_out) busy_seen = 1;
            if (hold) begin
                checks++;
                if ({valid_out, x_addr_out, h_addr_out, y_addr_out, first_out, last_out, busy_out, done_out} !== saved) begin
                    errors++;
                    $display("FAIL hold_stable cyc=%0d got=%h expected=%h", cyc,
                             {valid_out, x_addr_out, h_addr_out, y_addr_out, first_out, last_out, busy_out, done_out}, saved);
                end
            end
            if (valid_out) begin
                checks++;
                if (b >= nexp) begin
                    errors++;
                    $display("FAIL extra_beat idx=%0d got y=%0d expected no beat", b, y_addr_out);
                end else if (x_addr_out !== exp_x[b] || h_addr_out !== exp_h[b] || y_addr_out !== exp_y[b] ||
                             first_out !== exp_f[b] || last_out !== exp_l[b]) begin
                    errors++;
                    $display("FAIL beat[%0d] got x=%0d h=%0d y=%0d f=%b l=%b expected x=%0d h=%0d y=%0d f=%b l=%b",
                             b, x_addr_out, h_addr_out, y_addr_out, first_out, last_out,
                             exp_x[b], exp_h[b], exp_y[b], exp_f[b], exp_l[b]);
                end
            end
            if (done_out) begin
                done_cyc = cyc;
                fin = 1;
            end else if (cyc >= 4000) begin
                checks++; errors++;
                $display("FAIL timeout cyc=%0d got no done_out expected done_out", cyc);
                fin = 1;
            end else if (abort_at >= 0 && valid_out && b == abort_at) begin
                #2 rst = 1'b1;
                #1;
                checks++;
                if ({valid_out, x_addr_out, h_addr_out, y_addr_out, first_out, last_out, busy_out, done_out} !== '0) begin
                    errors++;
                    $display("FAIL async_reset_outputs got=%h expected=0",
                             {valid_out, x_addr_out, h_addr_out, y_addr_out, first_out, last_out, busy_out, done_out});
                end
                fin = 1;
            end else begin
                if (cyc == poke_at) begin
                    start_in = 1'b1; m_len_in = 8'd3; n_len_in = 8'd5;
                end else begin
                    start_in = 1'b0; m_len_in = 8'(m); n_len_in = 8'(n);
                end
                ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                hold  = valid_out && !ready_in;
                saved = {valid_out, x_addr_out, h_addr_out, y_addr_out, first_out, last_out, busy_out, done_out};
                if (valid_out && ready_in) begin
                    if (last_out) lasts++;
                    b++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        beats = b;
        if (abort_at < 0 && done_cyc >= 0) begin
            @(negedge clk);
            checks++;
            if (done_out !== 1'b0 || busy_out !== 1'b0 || valid_out !== 1'b0) begin
                errors++;
                $display("FAIL done_one_cycle got done=%b busy=%b valid=%b expected 0 0 0", done_out, busy_out, valid_out);
            end
        end
    endtask

    task automatic check_totals(input string tag, input int beats, input int lasts, input int done_cyc,
                                input int e_beats, input int e_lasts, input int e_done);
        checks++;
        if (beats !== e_beats) begin
            errors++;
            $display("FAIL %s_beats got=%0d expected=%0d", tag, beats, e_beats);
        end
        checks++;
        if (lasts !== e_lasts) begin
            errors++;
            $display("FAIL %s_lasts got=%0d expected=%0d", tag, lasts, e_lasts);
        end
        checks++;
        if (done_cyc !== e_done) begin
            errors++;
            $display("FAIL %s_done_cycle got=%0d expected=%0d", tag, done_cyc, e_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({valid_out, x_addr_out, h_addr_out, y_addr_out, first_out, last_out, busy_out, done_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h expected=0",
                     {valid_out, x_addr_out, h_addr_out, y_addr_out, first_out, last_out, busy_out, done_out});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_out !== 1'b0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b valid=%b expected 0 0", busy_out, valid_out);
        end
    endtask

    task automatic test_small();
        int beats, lasts, dc;
        bit bs;
        // hand table for M=2, N=3: (x,h,y), first, last
        exp_x[0]=0; exp_h[0]=0; exp_y[0]=0; exp_f[0]=1; exp_l[0]=1;
        exp_x[1]=1; exp_h[1]=0; exp_y[1]=1; exp_f[1]=1; exp_l[1]=0;
        exp_x[2]=0; exp_h[2]=1; exp_y[2]=1; exp_f[2]=0; exp_l[2]=1;
        exp_x[3]=2; exp_h[3]=0; exp_y[3]=2; exp_f[3]=1; exp_l[3]=0;
        exp_x[4]=1; exp_h[4]=1; exp_y[4]=2; exp_f[4]=0; exp_l[4]=1;
        exp_x[5]=2; exp_h[5]=1; exp_y[5]=3; exp_f[5]=1; exp_l[5]=1;
        run_job(2, 3, 6, 0, -1, -1, beats, lasts, dc, bs);
        check_totals("small", beats, lasts, dc, 6, 4, 11);
    endtask

    task automatic test_full();
        int beats, lasts, dc, nexp;
        bit bs;
        nexp = build_model(8, 32);
        run_job(8, 32, nexp, 0, -1, -1, beats, lasts, dc, bs);
        check_totals("full", beats, lasts, dc, 256, 39, 296);
    endtask

    task automatic test_one_tap();
        int beats, lasts, dc, nexp;
        bit bs;
        nexp = build_model(1, 5);
        run_job(1, 5, nexp, 0, -1, -1, beats, lasts, dc, bs);
        check_totals("m1", beats, lasts, dc, 5, 5, 11);
        nexp = build_model(4, 1);
        run_job(4, 1, nexp, 0, -1, -1, beats, lasts, dc, bs);
        check_totals("n1", beats, lasts, dc, 4, 4, 9);
    endtask

    task automatic test_backpressure();
        int beats, lasts, dc, nexp;
        bit bs;
        nexp = build_model(8, 32);
        run_job(8, 32, nexp, 1, -1, -1, beats, lasts, dc, bs);
        checks++;
        if (beats !== 256 || lasts !== 39) begin
            errors++;
            $display("FAIL bp_totals got beats=%0d lasts=%0d expected 256 39", beats, lasts);
        end
        checks++;
        if (dc < 296) begin
            errors++;
            $display("FAIL bp_done_cycle got=%0d expected>=296", dc);
        end
    endtask

    task automatic test_zero_len();
        int beats, lasts, dc;
        bit bs;
        run_job(0, 32, 0, 0, -1, -1, beats, lasts, dc, bs);
        check_totals("zero", beats, lasts, dc, 0, 0, 1);
        checks++;
        if (bs !== 1'b0) begin
            errors++;
            $display("FAIL zero_busy got=%b expected=0", bs);
        end
    endtask

    task automatic test_reset_midjob();
        int beats, lasts, dc, nexp;
        bit bs;
        nexp = build_model(8, 32);
        run_job(8, 32, nexp, 0, 100, -1, beats, lasts, dc, bs);
        checks++;
        if (dc !== -1) begin
            errors++;
            $display("FAIL abort_no_done got done_cyc=%0d expected none", dc);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (done_out !== 1'b0 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got done=%b busy=%b expected 0 0", done_out, busy_out);
        end
        run_job(8, 32, nexp, 0, -1, -1, beats, lasts, dc, bs);
        check_totals("restart", beats, lasts, dc, 256, 39, 296);
    endtask

    task automatic test_start_ignored();
        int beats, lasts, dc, nexp;
        bit bs;
        nexp = build_model(8, 32);
        run_job(8, 32, nexp, 0, -1, 20, beats, lasts, dc, bs);
        check_totals("ignore", beats, lasts, dc, 256, 39, 296);
    endtask

    initial begin
        test_reset();
        test_small();
        test_full();
        test_one_tap();
        test_backpressure();
        test_zero_len();
        test_reset_midjob();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
